// File: rtl/mx_pkg.sv
// rtl/mx_pkg.sv - shared constants for the round-robin/fixed-select output mux
//
// MX_WIDTH / MX_N : default data width and channel count
// MODE_RR         : mode value selecting round-robin arbitration
// MODE_FIX        : mode value selecting the channel given by sel
package mx_pkg;

  localparam int MX_WIDTH = 32;
  localparam int MX_N     = 8;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_FIX = 1'b1;

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - combinational round-robin arbiter, double-width masked priority
//
// req   [N]    : request per channel
// ptr   [SELW] : last granted channel; search starts at ptr+1 modulo N
// grant [N]    : one-hot grant, all zero when nothing requests
// gidx  [SELW] : encoded index of the granted channel (0 when none)
// any          : at least one request present
module rr_arbiter_n #(
  parameter int N    = 8,
  parameter int SELW = 3
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] gidx,
  output logic            any
);

  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [SELW:0]    start;
  logic [2*N-1:0]   dbl;
  logic [2*N-1:0]   keep;
  logic [2*N-1:0]   masked;
  logic [2*N-1:0]   first;

  // Two copies of req side by side: clearing bits [0..ptr] of the lower copy
  // leaves the wrapped-around candidates in the upper copy, so the lowest
  // surviving bit is the next requester after ptr, modulo N (not 2^SELW).
  assign start  = {1'b0, ptr} + {{SELW{1'b0}}, 1'b1};
  assign dbl    = {req, req};
  assign keep   = ~((ONE << start) - ONE);
  assign masked = dbl & keep;
  assign first  = masked & (~masked + ONE);

  assign grant = first[N-1:0] | first[2*N-1:N];
  assign any   = |req;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gidx = SELW'(i);
    end
  end

endmodule

// File: rtl/mx_rr_n.sv
// rtl/mx_rr_n.sv - N-channel registered mux with round-robin or fixed selection
//
// clk, reset_n         : clock (rising edge), asynchronous active-low reset
// mode, sel            : 0 = round-robin, 1 = take channel sel (sel >= N selects nothing)
// in_valid/in_data     : per-channel requests, channel i at in_data[i*WIDTH +: WIDTH]
// in_ready             : per-channel accept
// out_valid/out_data   : one-stage output register
// out_ch               : channel that produced out_data
// out_ready            : downstream accept
module mx_rr_n
  import mx_pkg::*;
#(
  parameter int WIDTH = MX_WIDTH,
  parameter int N     = MX_N,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_ch,
  input  logic             out_ready
);

  logic [SELW-1:0]  rr_ptr;
  logic [N-1:0]     arb_grant;
  logic [SELW-1:0]  arb_gidx;
  logic             arb_any;

  logic [N-1:0]     grant;
  logic [SELW-1:0]  g_idx;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter_n #(.N(N), .SELW(SELW)) u_arb (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .gidx  (arb_gidx),
    .any   (arb_any)
  );

  always_comb begin
    grant = '0;
    g_idx = '0;
    if (mode == MODE_RR) begin
      grant = arb_grant;
      g_idx = arb_any ? arb_gidx : '0;
    end else if (int'(sel) < N) begin
      grant[sel] = in_valid[sel];
      g_idx      = sel;
    end
  end

  // Register is empty or being drained this cycle, so it can take a new word.
  assign load     = !out_valid || out_ready;
  assign in_ready = grant & {N{load}};
  assign xfer     = |in_ready;
  assign sel_data = in_data[int'(g_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(N-1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= g_idx;
      if (mode == MODE_RR) rr_ptr <= g_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mx_rr_n.sv
// tb/tb_mx_rr_n.sv - directed self-checking bench for mx_rr_n (N=8 and N=6 instances)
module tb_mx_rr_n;

  logic          clk;
  logic          reset_n;

  logic          mode;
  logic [2:0]    sel;
  logic [7:0]    in_valid;
  logic [255:0]  in_data;
  logic [7:0]    in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [2:0]    out_ch;
  logic          out_ready;

  logic          mode6;
  logic [2:0]    sel6;
  logic [5:0]    in_valid6;
  logic [95:0]   in_data6;
  logic [5:0]    in_ready6;
  logic          out_valid6;
  logic [15:0]   out_data6;
  logic [2:0]    out_ch6;
  logic          out_ready6;

  int chk_cnt;
  int pass_cnt;

  mx_rr_n #(.WIDTH(32), .N(8), .SELW(3)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  mx_rr_n #(.WIDTH(16), .N(6), .SELW(3)) u_dut6 (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode6),
    .sel       (sel6),
    .in_valid  (in_valid6),
    .in_data   (in_data6),
    .in_ready  (in_ready6),
    .out_valid (out_valid6),
    .out_data  (out_data6),
    .out_ch    (out_ch6),
    .out_ready (out_ready6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    reset_n   = 1'b0;
    mode      = 1'b0;
    sel       = 3'd0;
    in_valid  = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    mode6      = 1'b0;
    sel6       = 3'd0;
    in_valid6  = 6'h00;
    out_ready6 = 1'b1;
    for (int i = 0; i < 6; i++) in_data6[i*16 +: 16] = 16'hB000 + 16'(i);

    // reset then idle
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // full round-robin rotation, channel 0 first after reset
    in_valid = 8'hFF;
    #1;
    check("rr_first_ready", 64'(in_ready), 64'h01);
    for (int k = 0; k < 9; k++) begin
      step();
      check($sformatf("rr_ch%0d", k), 64'(out_ch), 64'(k % 8));
      check($sformatf("rr_data%0d", k), 64'(out_data), 64'(32'hA000_0000 + 32'(k % 8)));
      check($sformatf("rr_valid%0d", k), 64'(out_valid), 64'd1);
    end

    // sparse: bring rr_ptr to 5, then channels 2 and 5 alternate
    in_valid = 8'h20;
    step();
    check("sp_prime_ch", 64'(out_ch), 64'd5);
    in_valid = 8'h24;
    #1;
    check("sp_ready0", 64'(in_ready), 64'h04);
    step();
    check("sp_ch0", 64'(out_ch), 64'd2);
    check("sp_ready1", 64'(in_ready), 64'h20);
    step();
    check("sp_ch1", 64'(out_ch), 64'd5);
    check("sp_ready2", 64'(in_ready), 64'h04);
    step();
    check("sp_ch2", 64'(out_ch), 64'd2);

    // back-pressure holding ch3 word, then no-bubble reload
    in_data[3*32 +: 32] = 32'hDEAD_BEEF;
    in_valid = 8'h08;
    step();
    check("bp_load_ch", 64'(out_ch), 64'd3);
    check("bp_load_data", 64'(out_data), 64'hDEAD_BEEF);
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), 64'(in_ready), 64'h00);
      step();
      check($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("bp_data%0d", k), 64'(out_data), 64'hDEAD_BEEF);
      check($sformatf("bp_ch%0d", k), 64'(out_ch), 64'd3);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'h10);
    step();
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_ch", 64'(out_ch), 64'd4);
    check("bp_next_data", 64'(out_data), 64'hA000_0004);

    // fixed select on channel 6
    mode     = 1'b1;
    sel      = 3'd6;
    in_valid = 8'hC0;
    #1;
    check("fix_ready0", 64'(in_ready), 64'h40);
    step();
    check("fix_ch0", 64'(out_ch), 64'd6);
    check("fix_data0", 64'(out_data), 64'hA000_0006);
    check("fix_ready1", 64'(in_ready), 64'h40);
    step();
    check("fix_ch1", 64'(out_ch), 64'd6);
    in_valid = 8'h80;
    #1;
    check("fix_novalid_ready", 64'(in_ready), 64'h00);
    step();
    check("fix_drain_valid", 64'(out_valid), 64'd0);
    check("fix_drain_data", 64'(out_data), 64'hA000_0006);

    // back to round-robin: pointer still at 4 from before fixed mode
    mode     = 1'b0;
    in_valid = 8'hFF;
    #1;
    check("rr_resume_ready", 64'(in_ready), 64'h20);
    step();
    check("rr_resume_ch", 64'(out_ch), 64'd5);
    check("ar_pre_valid", 64'(out_valid), 64'd1);

    // asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_data", 64'(out_data), 64'd0);
    check("ar_ch", 64'(out_ch), 64'd0);
    step();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ar_first_ready", 64'(in_ready), 64'h01);
    step();
    check("ar_first_ch", 64'(out_ch), 64'd0);
    in_valid = 8'h00;

    // N=6: wrap from channel 5 to channel 0, and sel >= N accepts nothing
    in_valid6 = 6'h20;
    step();
    check("n6_ch5", 64'(out_ch6), 64'd5);
    in_valid6 = 6'h21;
    #1;
    check("n6_wrap_ready", 64'(in_ready6), 64'h01);
    step();
    check("n6_wrap_ch", 64'(out_ch6), 64'd0);
    check("n6_wrap_data", 64'(out_data6), 64'hB000);
    mode6     = 1'b1;
    sel6      = 3'd7;
    in_valid6 = 6'h3F;
    #1;
    check("n6_sel7_ready", 64'(in_ready6), 64'h00);
    sel6 = 3'd6;
    #1;
    check("n6_sel6_ready", 64'(in_ready6), 64'h00);
    step();
    check("n6_drain_valid", 64'(out_valid6), 64'd0);
    sel6 = 3'd5;
    #1;
    check("n6_sel5_ready", 64'(in_ready6), 64'h20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
